bus_master_port: RTL and testbench
==================================

// Module: bus_master_port
// PURPOSE
//  Master-side bus interface: one instance per master (M1, M2), directly downstream of the test controller.
//  Latches an enable/read_en/addr/data command, requests the shared serial bus from the arbiter and shifts out the frame.
//  Collects the slave ack and, for reads, the returned byte; drives `request` back to the controller while busy.
//  addr[13:12] selects slave (0..2), addr[11:0] is the offset inside the slave.
// PARAMETERS
//  ADDR_WIDTH   14  command address width; frame carries all bits
//  DATA_WIDTH   8   data width for write payload and read return
//  ACK_TIMEOUT  16  max cycles waited for slave_ack / read data before abort
// PORTS
//  clk            in   1   sole clock, all logic on posedge
//  reset          in   1   synchronous, active-low reset
//  enable         in   1   command strobe from controller, sampled in IDLE only
//  read_en        in   1   1 = read, 0 = write; latched with enable
//  data_in        in   8   write payload, latched with enable
//  addr_in        in   14  target address, latched with enable
//  request        out  1   high while a command is in flight (busy)
//  bus_req        out  1   request to bus arbiter
//  bus_grant      in   1   grant from bus arbiter
//  tx_bit         out  1   serial frame bit toward slaves
//  tx_valid       out  1   tx_bit qualifier
//  rx_bit         in   1   serial read-data bit from slave
//  rx_valid       in   1   rx_bit qualifier
//  slave_ack      in   1   slave accepted frame (1-cycle pulse)
//  data_out       out  8   read result, held until next read completes
//  data_out_valid out  1   1-cycle pulse when data_out updated
//  error          out  1   1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; all outputs 0, data_out=0; bit/timeout counters and latches cleared. Applies from any state.
//  All outputs registered. Frame: 14 addr bits LSB first, then 1 mode bit (1=read), then 8 data bits LSB first (write only).
//  IDLE: enable==1 -> latch read_en/addr/data, next REQ; request=1, bus_req=1 from next cycle. enable outside IDLE ignored.
//  REQ: hold bus_req; bus_grant==1 sampled -> ADDR, bit counter=0. No timeout in REQ.
//  ADDR: tx_valid=1, one bit/cycle, 15 cycles (addr+mode). Then read -> WAIT_ACK; write -> WDATA.
//  WDATA: tx_valid=1, 8 cycles of data bits -> WAIT_ACK.
//  Grant loss: bus_grant==0 during ADDR/WDATA -> tx_valid=0 next cycle, state REQ, frame restarts at bit 0 on regrant; latches kept.
//  WAIT_ACK: tx_valid=0, bus_req held; timeout counter starts at 0. slave_ack -> write: DONE; read: RDATA (counter reset).
//   ACK_TIMEOUT cycles without ack -> error pulse, DONE.
//  RDATA: shift rx_bit on each rx_valid, LSB first; after 8th bit data_out=byte, data_out_valid pulse, DONE.
//   Timeout counter resets on each rx_valid; ACK_TIMEOUT idle cycles -> error pulse, data_out unchanged, DONE.
//  DONE (1 cycle): bus_req=0, request=0 -> IDLE. Next command accepted no earlier than the cycle after DONE.
//  slave_ack/rx_valid outside WAIT_ACK/RDATA ignored. Ack and timeout in same cycle: ack wins.
//  Min write latency (grant immediate): enable cycle + REQ 1 + 15 + 8 + ack wait + DONE 1.
// TESTING
//  Write addr 1001 data 101, grant immediate, ack 3 cycles after frame -> 23 tx bits = addr LSB-first, 0, 0x65 LSB-first; request low after DONE.
//  Read addr 5097, ack then rx byte 0x5A (rx_valid gapped 2 cycles) -> data_out=0x5A, one data_out_valid pulse, error=0.
//  Write with grant dropped after addr bit 6, regranted 4 cycles later -> frame restarts at bit 0, full 23 bits sent once.
//  Read addr 9193, no slave_ack -> error pulse exactly ACK_TIMEOUT cycles into WAIT_ACK, data_out unchanged, request drops.
//  enable pulsed again mid-WDATA -> ignored, latched data unchanged; reset low mid-WDATA -> all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/bus_master_port.sv
// Master-side serial bus port: latches a controller command, wins the bus from the
// arbiter, shifts out the address/mode/data frame and collects the slave's ack and read byte.
module bus_master_port #(
   parameter int ADDR_WIDTH  = 14,
   parameter int DATA_WIDTH  = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  read_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   output logic                  request,
   output logic                  bus_req,
   input  logic                  bus_grant,
   output logic                  tx_bit,
   output logic                  tx_valid,
   input  logic                  rx_bit,
   input  logic                  rx_valid,
   input  logic                  slave_ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   output logic                  error
);

   localparam int FRAME_LEN = ADDR_WIDTH + 1 + DATA_WIDTH;
   localparam int IDX_W     = $clog2(FRAME_LEN + 1);
   localparam int TMO_W     = $clog2(ACK_TIMEOUT + 1);
   localparam int RX_W      = $clog2(DATA_WIDTH + 1);

   localparam logic [IDX_W-1:0] HDR_LEN   = IDX_W'(ADDR_WIDTH + 1);
   localparam logic [IDX_W-1:0] FULL_LEN  = IDX_W'(FRAME_LEN);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [RX_W-1:0]  RX_LAST   = RX_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_REQ      = 3'd1;
   localparam logic [2:0] S_ADDR     = 3'd2;
   localparam logic [2:0] S_WDATA    = 3'd3;
   localparam logic [2:0] S_WAIT_ACK = 3'd4;
   localparam logic [2:0] S_RDATA    = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   logic [2:0]            state;
   logic [FRAME_LEN-1:0]  frame_q;
   logic                  rd_q;
   logic [IDX_W-1:0]      idx;
   logic [TMO_W-1:0]      tmo;
   logic [RX_W-1:0]       rx_cnt;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [IDX_W-1:0]      frame_end;

   // Reads stop after the mode bit; writes carry the payload as well.
   assign frame_end = rd_q ? HDR_LEN : FULL_LEN;

   // idx counts frame bits already put on tx_bit, so a grant loss can rewind it to zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         frame_q        <= '0;
         rd_q           <= 1'b0;
         idx            <= '0;
         tmo            <= '0;
         rx_cnt         <= '0;
         rx_shift       <= '0;
         request        <= 1'b0;
         bus_req        <= 1'b0;
         tx_bit         <= 1'b0;
         tx_valid       <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         error          <= 1'b0;
      end else begin
         data_out_valid <= 1'b0;
         error          <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  frame_q <= {data_in, read_en, addr_in};
                  rd_q    <= read_en;
                  request <= 1'b1;
                  bus_req <= 1'b1;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus_grant) begin
                  tx_valid <= 1'b1;
                  tx_bit   <= frame_q[0];
                  idx      <= IDX_W'(1);
                  state    <= S_ADDR;
               end
            end
            S_ADDR, S_WDATA: begin
               if (!bus_grant) begin
                  tx_valid <= 1'b0;
                  tx_bit   <= 1'b0;
                  idx      <= '0;
                  state    <= S_REQ;
               end else if (idx == frame_end) begin
                  tx_valid <= 1'b0;
                  tx_bit   <= 1'b0;
                  tmo      <= '0;
                  state    <= S_WAIT_ACK;
               end else begin
                  tx_bit <= frame_q[idx];
                  idx    <= idx + 1'b1;
                  state  <= (idx >= HDR_LEN) ? S_WDATA : S_ADDR;
               end
            end
            // An ack arriving on the timeout cycle still counts as success.
            S_WAIT_ACK: begin
               if (slave_ack) begin
                  if (rd_q) begin
                     tmo    <= '0;
                     rx_cnt <= '0;
                     state  <= S_RDATA;
                  end else begin
                     request <= 1'b0;
                     bus_req <= 1'b0;
                     state   <= S_DONE;
                  end
               end else if (tmo == TMO_LAST) begin
                  error   <= 1'b1;
                  request <= 1'b0;
                  bus_req <= 1'b0;
                  state   <= S_DONE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_RDATA: begin
               if (rx_valid) begin
                  rx_shift <= {rx_bit, rx_shift[DATA_WIDTH-1:1]};
                  tmo      <= '0;
                  if (rx_cnt == RX_LAST) begin
                     data_out       <= {rx_bit, rx_shift[DATA_WIDTH-1:1]};
                     data_out_valid <= 1'b1;
                     request        <= 1'b0;
                     bus_req        <= 1'b0;
                     state          <= S_DONE;
                  end else begin
                     rx_cnt <= rx_cnt + 1'b1;
                  end
               end else if (tmo == TMO_LAST) begin
                  error   <= 1'b1;
                  request <= 1'b0;
                  bus_req <= 1'b0;
                  state   <= S_DONE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: expected frame bits, read bytes and error
// pulses are queued when commands are driven and retired as the port produces them.
module tb_bus_master_port;

   localparam int ACK_TIMEOUT = 16;
   localparam int BOUND       = 400;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        read_en;
   logic [7:0]  data_in;
   logic [13:0] addr_in;
   logic        request;
   logic        bus_req;
   logic        bus_grant;
   logic        tx_bit;
   logic        tx_valid;
   logic        rx_bit;
   logic        rx_valid;
   logic        slave_ack;
   logic [7:0]  data_out;
   logic        data_out_valid;
   logic        error;

   int tests_run    = 0;
   int tests_failed = 0;
   int dov_count    = 0;
   int err_count    = 0;

   bit         exp_tx[$];
   logic [7:0] exp_rd[$];
   bit         exp_err[$];

   bus_master_port #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .read_en        (read_en),
      .data_in        (data_in),
      .addr_in        (addr_in),
      .request        (request),
      .bus_req        (bus_req),
      .bus_grant      (bus_grant),
      .tx_bit         (tx_bit),
      .tx_valid       (tx_valid),
      .rx_bit         (rx_bit),
      .rx_valid       (rx_valid),
      .slave_ack      (slave_ack),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .error          (error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Frame model: address LSB first, mode bit, then payload LSB first for writes.
   task automatic pushFrame(input bit rd, input logic [13:0] addr, input logic [7:0] data, input int nbits);
      bit fb[$];
      for (int i = 0; i < 14; i++) fb.push_back(addr[i]);
      fb.push_back(rd);
      if (!rd) for (int i = 0; i < 8; i++) fb.push_back(data[i]);
      for (int i = 0; i < nbits && i < fb.size(); i++) exp_tx.push_back(fb[i]);
   endtask

   task automatic applyStimulus(input bit rd, input logic [13:0] addr, input logic [7:0] data);
      @(negedge clk);
      enable  = 1'b1;
      read_en = rd;
      addr_in = addr;
      data_in = data;
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic waitBits(input int nbits);
      int seen = 0;
      int cyc  = 0;
      while (seen < nbits && cyc < BOUND) begin
         @(negedge clk);
         cyc++;
         if (tx_valid) seen++;
      end
      if (cyc >= BOUND) checkOutput("bits_wait", seen, nbits);
   endtask

   task automatic waitTx(input int nbits);
      int  seen = 0;
      int  cyc  = 0;
      bit  done = 1'b0;
      while (!done && cyc < BOUND) begin
         @(negedge clk);
         cyc++;
         if (tx_valid) seen++;
         else if (seen >= nbits) done = 1'b1;
      end
      if (!done) checkOutput("frame_wait", seen, nbits);
   endtask

   task automatic sendAck(input int delay);
      repeat (delay) @(negedge clk);
      slave_ack = 1'b1;
      @(negedge clk);
      slave_ack = 1'b0;
   endtask

   always @(negedge clk) begin
      if (tx_valid === 1'b1) begin
         if (exp_tx.size() == 0) checkOutput("tx_unexpected", 1, 0);
         else checkOutput("tx_bit", tx_bit, exp_tx.pop_front());
      end
      if (data_out_valid === 1'b1) begin
         dov_count++;
         if (exp_rd.size() == 0) checkOutput("dov_unexpected", 1, 0);
         else checkOutput("data_out", data_out, exp_rd.pop_front());
      end
      if (error === 1'b1) begin
         err_count++;
         if (exp_err.size() == 0) checkOutput("error_unexpected", 1, 0);
         else checkOutput("error", error, exp_err.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] rbyte;
      int         n;
      reset = 1'b0; enable = 1'b0; read_en = 1'b0; data_in = '0; addr_in = '0;
      bus_grant = 1'b1; rx_bit = 1'b0; rx_valid = 1'b0; slave_ack = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_request", request, 0);
      checkOutput("rst_bus_req", bus_req, 0);
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_data_out", data_out, 0);
      checkOutput("rst_dov", data_out_valid, 0);
      checkOutput("rst_error", error, 0);
      reset = 1'b1;
      @(negedge clk);

      // Write 1001 / 0x65, immediate grant, ack three cycles after the frame.
      pushFrame(1'b0, 14'd1001, 8'h65, 23);
      applyStimulus(1'b0, 14'd1001, 8'h65);
      checkOutput("wr_request", request, 1);
      checkOutput("wr_bus_req", bus_req, 1);
      waitTx(23);
      checkOutput("wr_waitack_request", request, 1);
      sendAck(3);
      checkOutput("wr_done_request", request, 0);
      checkOutput("wr_done_bus_req", bus_req, 0);
      checkOutput("wr_tx_drained", exp_tx.size(), 0);

      // Read 5097, byte 0x5A returned with two idle cycles between bits.
      rbyte = 8'h5A;
      pushFrame(1'b1, 14'd5097, 8'h00, 15);
      exp_rd.push_back(rbyte);
      applyStimulus(1'b1, 14'd5097, 8'h00);
      waitTx(15);
      sendAck(1);
      for (int i = 0; i < 8; i++) begin
         rx_valid = 1'b1;
         rx_bit   = rbyte[i];
         @(negedge clk);
         rx_valid = 1'b0;
         rx_bit   = 1'b0;
         if (i == 7) checkOutput("rd_done_request", request, 0);
         repeat (2) @(negedge clk);
      end
      checkOutput("rd_dov_count", dov_count, 1);
      checkOutput("rd_err_count", err_count, 0);
      checkOutput("rd_data_held", data_out, 8'h5A);

      // Write with the grant withdrawn after address bit 6: partial frame then a full resend.
      pushFrame(1'b0, 14'd12345, 8'hC3, 7);
      pushFrame(1'b0, 14'd12345, 8'hC3, 23);
      applyStimulus(1'b0, 14'd12345, 8'hC3);
      waitBits(7);
      bus_grant = 1'b0;
      @(negedge clk);
      checkOutput("gl_tx_valid", tx_valid, 0);
      checkOutput("gl_bus_req", bus_req, 1);
      repeat (3) @(negedge clk);
      bus_grant = 1'b1;
      waitTx(23);
      sendAck(0);
      checkOutput("gl_done_request", request, 0);
      checkOutput("gl_tx_drained", exp_tx.size(), 0);

      // Read 9193 with no slave ack: error must land ACK_TIMEOUT cycles into WAIT_ACK.
      pushFrame(1'b1, 14'd9193, 8'h00, 15);
      exp_err.push_back(1'b1);
      applyStimulus(1'b1, 14'd9193, 8'h00);
      waitTx(15);
      n = 0;
      while (error !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      checkOutput("to_cycles", n, ACK_TIMEOUT);
      checkOutput("to_request", request, 0);
      checkOutput("to_data_kept", data_out, 8'h5A);
      @(negedge clk);
      checkOutput("to_err_count", err_count, 1);
      checkOutput("to_dov_count", dov_count, 1);

      // A second enable during WDATA must not disturb the frame or start a new command.
      pushFrame(1'b0, 14'd300, 8'h3C, 23);
      applyStimulus(1'b0, 14'd300, 8'h3C);
      waitBits(18);
      enable  = 1'b1;
      read_en = 1'b1;
      addr_in = 14'h3FFF;
      data_in = 8'hFF;
      @(negedge clk);
      enable = 1'b0;
      waitTx(0);
      sendAck(0);
      repeat (3) @(negedge clk);
      checkOutput("ign_request", request, 0);
      checkOutput("ign_tx_drained", exp_tx.size(), 0);

      // Reset asserted mid-WDATA clears everything on the next edge.
      pushFrame(1'b0, 14'd77, 8'h81, 18);
      applyStimulus(1'b0, 14'd77, 8'h81);
      waitBits(18);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mr_request", request, 0);
      checkOutput("mr_bus_req", bus_req, 0);
      checkOutput("mr_tx_valid", tx_valid, 0);
      checkOutput("mr_data_out", data_out, 0);
      checkOutput("mr_dov", data_out_valid, 0);
      checkOutput("mr_error", error, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("mr_idle_request", request, 0);
      checkOutput("mr_tx_drained", exp_tx.size(), 0);
      checkOutput("rd_queue_drained", exp_rd.size(), 0);
      checkOutput("err_queue_drained", exp_err.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
